// File: rtl/mem_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder_pkg
// Brief    : Shared types and constants for the memory bus responder:
//            transfer state encoding and burst length.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_responder_pkg;

    // Transfer sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of bytes moved by a burst request
    localparam int BURST_LEN = 4;

    // Index of the final byte of a transfer (burst -> 3, single -> 0)
    function automatic logic [1:0] last_byte_idx(input logic burst);
        return burst ? 2'(BURST_LEN - 1) : 2'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_responder_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : byte_ram
// Brief    : Byte-wide storage array, synchronous write, asynchronous read.
//            Contents are not initialised and survive reset.
// Revision : 1.0 - initial release
// ============================================================================
module byte_ram #(
    parameter int ADDR_BITS = 8
) (
    input  logic                 Clock,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wr_data,
    output logic [7:0]           rd_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [7:0] mem [0:DEPTH-1];

    // Store one byte on the rising edge when the write enable is high
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder
// Brief    : Memory bus slave. Accepts single-byte or 4-byte burst requests,
//            inserts WAIT_CYCLES wait states, moves one byte per cycle to or
//            from a byte RAM and signals completion with a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_BITS   = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req_CS,
    input  logic        Req_WR,
    input  logic        Req_Burst,
    input  logic [15:0] Req_Addr,
    input  logic [31:0] Req_WData,
    output logic [31:0] Rsp_RData,
    output logic        Rsp_Valid,
    output logic        Busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [1:0]             byte_idx;
    logic [1:0]             last_idx;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            wdata_q;
    logic                   wr_q;

    logic                   ram_wr_en;
    logic [ADDR_BITS-1:0]   ram_addr;
    logic [7:0]             ram_wr_data;
    logic [7:0]             ram_rd_data;

    // Address bits above ADDR_BITS are intentionally ignored
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^Req_Addr;

    // Current byte address wraps naturally within the ADDR_BITS-wide array
    assign ram_addr    = addr_q + ADDR_BITS'(byte_idx);
    assign ram_wr_en   = (state == ST_XFER) && wr_q;
    assign ram_wr_data = wdata_q[{byte_idx, 3'b000} +: 8];

    byte_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .Clock   (Clock),
        .wr_en   (ram_wr_en),
        .addr    (ram_addr),
        .wr_data (ram_wr_data),
        .rd_data (ram_rd_data)
    );

    // Request sequencer: accept, wait states, byte transfer, completion pulse
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            byte_idx  <= 2'd0;
            last_idx  <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            wr_q      <= 1'b0;
            Rsp_RData <= 32'd0;
            Rsp_Valid <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            Rsp_Valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!Req_CS) begin
                        addr_q    <= Req_Addr[ADDR_BITS-1:0];
                        wdata_q   <= Req_WData;
                        wr_q      <= Req_WR;
                        last_idx  <= last_byte_idx(Req_Burst);
                        byte_idx  <= 2'd0;
                        // Cleared so single reads have zero upper bytes and
                        // writes report zero data
                        Rsp_RData <= 32'd0;
                        Busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_XFER;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt <= 4'd0;
                        state    <= ST_XFER;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_XFER: begin
                    if (!wr_q) begin
                        Rsp_RData[{byte_idx, 3'b000} +: 8] <= ram_rd_data;
                    end
                    if (byte_idx == last_idx) begin
                        state     <= ST_DONE;
                        Rsp_Valid <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, giving wait states (0..15) inserted before data transfer.
REQ-002 SHALL have parameter ADDR_BITS, default 8, giving the byte-array depth of 2^ADDR_BITS.
REQ-003 SHALL have port Clock, input, 1, system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port Req_CS, input, 1, request strobe, active-low.
REQ-006 SHALL have port Req_WR, input, 1, 1=write, 0=read.
REQ-007 SHALL have port Req_Burst, input, 1, 1=4-byte burst, 0=single byte.
REQ-008 SHALL have port Req_Addr, input, 16, start byte address; only [ADDR_BITS-1:0] is used.
REQ-009 SHALL have port Req_WData, input, 32, write data; byte k is [8k+7:8k].
REQ-010 SHALL have port Rsp_RData, output, 32, assembled read data.
REQ-011 SHALL have port Rsp_Valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port Busy, output, 1, high whenever not IDLE.

Function
REQ-013 SHALL implement states IDLE, WAIT, XFER and DONE.
REQ-014 SHALL accept a request at a rising edge in IDLE with Req_CS=0, capturing Addr, WData, WR and Burst; N=4 if Burst=1, else N=1.
REQ-015 SHALL ignore Req_CS while Busy=1; no queuing and no effect on the transfer in flight.
REQ-016 SHALL go from IDLE to WAIT on accept, or straight to XFER when WAIT_CYCLES=0.
REQ-017 SHALL stay in WAIT exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then enter XFER.
REQ-018 SHALL move one byte per cycle in XFER, with byte k at captured address+k modulo 2^ADDR_BITS (0xFF wraps to 0x00).
REQ-019 SHALL, on write, store Req_WData byte k to memory in XFER cycle k.
REQ-020 SHALL, on read, load memory byte k into Rsp_RData[8k+7:8k] (little-endian).
REQ-021 SHALL, for a single read, zero Rsp_RData[31:8].
REQ-022 SHALL, for writes, drive Rsp_RData to 0.
REQ-023 SHALL go from XFER to DONE after the Nth byte, and hold DONE one cycle with Rsp_Valid=1.
REQ-024 SHALL return from DONE to IDLE; a request is next accepted on the edge leaving DONE+1 (IDLE).
REQ-025 SHALL raise Rsp_Valid W+N cycles after the accepting edge (W=WAIT_CYCLES), i.e. on rising edge W+N+1 counting the accept edge as edge 1.
REQ-026 SHALL hold Rsp_RData stable from DONE until the next accepted read.
REQ-027 SHALL, for a read overlapping bytes written earlier, return the most recently written values (no stale data).

Reset
REQ-028 SHALL on Reset force state=IDLE, Busy=0, Rsp_Valid=0, Rsp_RData=0 and wait counter=0.
REQ-029 SHALL abort any transfer when reset mid-operation, with no further memory writes after assertion; bytes already written remain.
REQ-030 SHALL NOT clear the memory array on reset; contents are undefined at power-up.

Structure
REQ-031 SHALL place the state encoding (IDLE, WAIT, XFER, DONE) and the burst length constant (4) in the shared CPU package.
REQ-032 SHALL instantiate one sub-module, byte_ram: synchronous-write, asynchronous-read, 8-bit wide, 2^ADDR_BITS deep.
REQ-033 SHALL keep all sequencing (FSM, counters, byte index, data assembly) in mem_bus_responder.

Verification
REQ-034 SHALL test burst write then burst read with W=1: write Addr=0x10, WData=0xDEADBEEF, Burst=1; then read Addr=0x10 -> Rsp_RData=0xDEADBEEF, Rsp_Valid on edge 6 after accept; mem[0x10]=0xEF, mem[0x13]=0xDE.
REQ-035 SHALL test single write and read: write 0x5A to Addr=0x20 with Burst=0; read Addr=0x20 -> Rsp_RData=0x0000005A, Rsp_Valid on edge 3.
REQ-036 SHALL test wrap-around: burst write 0x44332211 at Addr=0xFE -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33, mem[0x01]=0x44; burst read at 0xFE returns 0x44332211.
REQ-037 SHALL test busy rejection: assert Req_CS with a write to 0x30 during a read burst -> mem[0x30] unchanged, exactly one Rsp_Valid pulse.
REQ-038 SHALL test reset mid-burst: assert Reset after XFER byte 1 of a write of 0xAABBCCDD at 0x40 -> mem[0x40]=0xDD, mem[0x41]=0xCC, mem[0x42..0x43] unchanged, Busy=0, Rsp_Valid never pulses.
REQ-039 SHALL test W=0: a single read completes with Rsp_Valid on edge 2 after accept.
